painterengine_gpu_burst_reader: RTL and testbench

Single-burst AXI4 read master feeding one pixel FIFO of the GPU render pipeline. The renderer programs a 32-bit byte address and a pixel count, then raises the enable; the block issues one INCR burst of 32-bit pixels, pushes every returned word into its FIFO, and reports done or error. Two instances sit below the renderer: source pixels to FIFO1, destination pixels to FIFO2.

---
 rtl/painterengine_gpu_burst_reader_if.sv | 46 ++++
 rtl/painterengine_gpu_burst_reader.sv | 127 ++++++++++++
 tb/tb_painterengine_gpu_burst_reader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_burst_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | painterengine_gpu_burst_reader_if : renderer control, AXI4 AR/R, FIFO     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface painterengine_gpu_burst_reader_if;
  logic        i_wire_enable;
  logic [31:0] i_wire_address;
  logic [31:0] i_wire_length;
  logic        o_wire_done;
  logic        o_wire_error;
  logic [31:0] o_wire_araddr;
  logic [7:0]  o_wire_arlen;
  logic [2:0]  o_wire_arsize;
  logic [1:0]  o_wire_arburst;
  logic        o_wire_arvalid;
  logic        i_wire_arready;
  logic [31:0] i_wire_rdata;
  logic [1:0]  i_wire_rresp;
  logic        i_wire_rlast;
  logic        i_wire_rvalid;
  logic        o_wire_rready;
  logic [31:0] o_wire_fifo_wdata;
  logic        o_wire_fifo_wen;
  logic        i_wire_fifo_full;
  logic [31:0] o_wire_state;

  modport master (
    input  i_wire_enable, i_wire_address, i_wire_length,
    input  i_wire_arready, i_wire_rdata, i_wire_rresp, i_wire_rlast, i_wire_rvalid,
    input  i_wire_fifo_full,
    output o_wire_done, o_wire_error, o_wire_araddr, o_wire_arlen, o_wire_arsize,
    output o_wire_arburst, o_wire_arvalid, o_wire_rready,
    output o_wire_fifo_wdata, o_wire_fifo_wen, o_wire_state
  );

  modport slave (
    output i_wire_enable, i_wire_address, i_wire_length,
    output i_wire_arready, i_wire_rdata, i_wire_rresp, i_wire_rlast, i_wire_rvalid,
    output i_wire_fifo_full,
    input  o_wire_done, o_wire_error, o_wire_araddr, o_wire_arlen, o_wire_arsize,
    input  o_wire_arburst, o_wire_arvalid, o_wire_rready,
    input  o_wire_fifo_wdata, o_wire_fifo_wen, o_wire_state
  );
endinterface
`default_nettype wire

// File: rtl/painterengine_gpu_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | painterengine_gpu_burst_reader : one INCR AXI4 read burst into a FIFO     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module painterengine_gpu_burst_reader #(
  parameter int MAX_BURST = 8
) (
  input  logic i_wire_clock,
  input  logic i_wire_reset,
  painterengine_gpu_burst_reader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        arvalid_q, arvalid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic rready;
  logic beat;
  logic at_last;
  logic beat_bad;

  assign rready   = (state_q == ST_DATA) && !bus.i_wire_fifo_full;
  assign beat     = bus.i_wire_rvalid && rready;
  // arlen doubles as the index of the expected final beat
  assign at_last  = (cnt_q == arlen_q);
  assign beat_bad = (bus.i_wire_rresp != 2'b00) || (bus.i_wire_rlast != at_last);

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_wire_enable) begin
          if (bus.i_wire_length == 32'd0) begin
            state_d = ST_DONE;
          end else if ((bus.i_wire_length > 32'(MAX_BURST)) ||
                       (bus.i_wire_address[1:0] != 2'b00)) begin
            state_d = ST_ERROR;
          end else begin
            state_d  = ST_ADDR;
            araddr_d = bus.i_wire_address;
            arlen_d  = bus.i_wire_length[7:0] - 8'd1;
            cnt_d    = 8'd0;
            bad_d    = 1'b0;
          end
        end
      end
      ST_ADDR: begin
        if (bus.i_wire_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          bad_d = bad_q || beat_bad;
          if (bus.i_wire_rlast || at_last) begin
            state_d = (bad_q || beat_bad) ? ST_ERROR : ST_DONE;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!bus.i_wire_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arvalid_d = (state_d == ST_ADDR);
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q   <= ST_IDLE;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
      cnt_q     <= 8'd0;
      bad_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Once a beat goes bad, the rest of the burst is drained without FIFO writes
  assign bus.o_wire_fifo_wen   = beat && !bad_q && (bus.i_wire_rresp == 2'b00);
  assign bus.o_wire_fifo_wdata = bus.o_wire_fifo_wen ? bus.i_wire_rdata : 32'd0;
  assign bus.o_wire_rready     = rready;
  assign bus.o_wire_araddr     = araddr_q;
  assign bus.o_wire_arlen      = arlen_q;
  assign bus.o_wire_arsize     = 3'b010;
  assign bus.o_wire_arburst    = 2'b01;
  assign bus.o_wire_arvalid    = arvalid_q;
  assign bus.o_wire_done       = done_q;
  assign bus.o_wire_error      = error_q;
  assign bus.o_wire_state      = {29'd0, state_q};

endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_painterengine_gpu_burst_reader : directed bench for the burst reader   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_painterengine_gpu_burst_reader;

  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;
  logic [31:0] wq[$];

  painterengine_gpu_burst_reader_if bus();

  painterengine_gpu_burst_reader #(.MAX_BURST(8)) dut (
    .i_wire_clock (clk),
    .i_wire_reset (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_wire_fifo_wen === 1'b1) wq.push_back(bus.o_wire_fifo_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] l);
    bus.i_wire_address = a;
    bus.i_wire_length  = l;
    bus.i_wire_enable  = 1'b1;
    tick();
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    bus.i_wire_rvalid = 1'b1;
    bus.i_wire_rdata  = d;
    bus.i_wire_rresp  = resp;
    bus.i_wire_rlast  = last;
    tick();
  endtask

  task automatic idle_bus();
    bus.i_wire_rvalid = 1'b0;
    bus.i_wire_rlast  = 1'b0;
    bus.i_wire_rresp  = 2'b00;
    bus.i_wire_rdata  = 32'd0;
  endtask

  task automatic release_en();
    bus.i_wire_enable = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.i_wire_enable    = 1'b0;
    bus.i_wire_address   = 32'd0;
    bus.i_wire_length    = 32'd0;
    bus.i_wire_arready   = 1'b0;
    bus.i_wire_fifo_full = 1'b0;
    idle_bus();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_state",   bus.o_wire_state,      32'd0);
    chk("rst_arvalid", {31'd0, bus.o_wire_arvalid}, 32'd0);
    chk("rst_araddr",  bus.o_wire_araddr,     32'd0);
    chk("rst_arlen",   {24'd0, bus.o_wire_arlen}, 32'd0);
    chk("rst_rready",  {31'd0, bus.o_wire_rready}, 32'd0);
    chk("rst_wen",     {31'd0, bus.o_wire_fifo_wen}, 32'd0);
    chk("rst_done",    {31'd0, bus.o_wire_done}, 32'd0);
    chk("rst_error",   {31'd0, bus.o_wire_error}, 32'd0);
    chk("arsize",      {29'd0, bus.o_wire_arsize}, 32'd2);
    chk("arburst",     {30'd0, bus.o_wire_arburst}, 32'd1);

    // Length 8, immediate arready, clean beats 0xA0..0xA7
    wq.delete();
    bus.i_wire_arready = 1'b1;
    start(32'h1000_0000, 32'd8);
    chk("t1_state_addr", bus.o_wire_state, 32'd1);
    chk("t1_arvalid",    {31'd0, bus.o_wire_arvalid}, 32'd1);
    chk("t1_araddr",     bus.o_wire_araddr, 32'h1000_0000);
    chk("t1_arlen",      {24'd0, bus.o_wire_arlen}, 32'd7);
    tick();
    chk("t1_state_data", bus.o_wire_state, 32'd2);
    chk("t1_arvalid_lo", {31'd0, bus.o_wire_arvalid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.i_wire_rvalid = 1'b1;
      bus.i_wire_rdata  = 32'hA0 + 32'(i);
      bus.i_wire_rlast  = (i == 7);
      #1;
      chk("t1_wdata_pass", bus.o_wire_fifo_wdata, 32'hA0 + 32'(i));
      @(posedge clk);
      #1;
      if (i < 7) chk("t1_not_done_yet", {31'd0, bus.o_wire_done}, 32'd0);
    end
    idle_bus();
    chk("t1_done",  {31'd0, bus.o_wire_done}, 32'd1);
    chk("t1_error", {31'd0, bus.o_wire_error}, 32'd0);
    chk("t1_state_done", bus.o_wire_state, 32'd3);
    chk("t1_nwrites", 32'(wq.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("t1_fifo_data", wq[i], 32'hA0 + 32'(i));
    tick();
    chk("t1_done_sticky", {31'd0, bus.o_wire_done}, 32'd1);
    release_en();
    chk("t1_idle_again", bus.o_wire_state, 32'd0);
    chk("t1_done_clear", {31'd0, bus.o_wire_done}, 32'd0);

    // Length 3, delayed arready, FIFO full for 4 cycles on beat 2
    wq.delete();
    bus.i_wire_arready = 1'b0;
    start(32'h2000_0000, 32'd3);
    tick();
    tick();
    chk("t2_arvalid_hold", {31'd0, bus.o_wire_arvalid}, 32'd1);
    chk("t2_araddr_hold",  bus.o_wire_araddr, 32'h2000_0000);
    chk("t2_arlen",        {24'd0, bus.o_wire_arlen}, 32'd2);
    bus.i_wire_arready = 1'b1;
    tick();
    chk("t2_state_data", bus.o_wire_state, 32'd2);
    beat(32'hB0, 2'b00, 1'b0);
    beat(32'hB1, 2'b00, 1'b0);
    bus.i_wire_fifo_full = 1'b1;
    bus.i_wire_rvalid    = 1'b1;
    bus.i_wire_rdata     = 32'hB2;
    bus.i_wire_rlast     = 1'b1;
    #1;
    chk("t2_rready_stall", {31'd0, bus.o_wire_rready}, 32'd0);
    chk("t2_wen_stall",    {31'd0, bus.o_wire_fifo_wen}, 32'd0);
    repeat (4) tick();
    chk("t2_still_data", bus.o_wire_state, 32'd2);
    chk("t2_writes_mid", 32'(wq.size()), 32'd2);
    bus.i_wire_fifo_full = 1'b0;
    #1;
    chk("t2_rready_back", {31'd0, bus.o_wire_rready}, 32'd1);
    tick();
    idle_bus();
    chk("t2_done", {31'd0, bus.o_wire_done}, 32'd1);
    chk("t2_nwrites", 32'(wq.size()), 32'd3);
    chk("t2_w0", wq[0], 32'hB0);
    chk("t2_w1", wq[1], 32'hB1);
    chk("t2_w2", wq[2], 32'hB2);
    release_en();

    // Request checks: zero length, oversize, misaligned
    start(32'h3000_0000, 32'd0);
    chk("t3_len0_state",   bus.o_wire_state, 32'd3);
    chk("t3_len0_done",    {31'd0, bus.o_wire_done}, 32'd1);
    chk("t3_len0_arvalid", {31'd0, bus.o_wire_arvalid}, 32'd0);
    release_en();
    chk("t3_len0_idle", bus.o_wire_state, 32'd0);
    start(32'h3000_0000, 32'd9);
    chk("t3_len9_error",   {31'd0, bus.o_wire_error}, 32'd1);
    chk("t3_len9_state",   bus.o_wire_state, 32'd4);
    chk("t3_len9_arvalid", {31'd0, bus.o_wire_arvalid}, 32'd0);
    release_en();
    chk("t3_err_clear", {31'd0, bus.o_wire_error}, 32'd0);
    start(32'h0000_1002, 32'd4);
    chk("t3_mis_error",   {31'd0, bus.o_wire_error}, 32'd1);
    chk("t3_mis_arvalid", {31'd0, bus.o_wire_arvalid}, 32'd0);
    release_en();

    // Length 4, SLVERR on beat 1: all beats drained, only beat 0 written
    wq.delete();
    start(32'h3000_0100, 32'd4);
    tick();
    beat(32'hC0, 2'b00, 1'b0);
    beat(32'hC1, 2'b10, 1'b0);
    beat(32'hC2, 2'b00, 1'b0);
    chk("t4_draining", bus.o_wire_state, 32'd2);
    beat(32'hC3, 2'b00, 1'b1);
    idle_bus();
    chk("t4_error",   {31'd0, bus.o_wire_error}, 32'd1);
    chk("t4_done",    {31'd0, bus.o_wire_done}, 32'd0);
    chk("t4_nwrites", 32'(wq.size()), 32'd1);
    chk("t4_w0",      wq[0], 32'hC0);
    release_en();

    // Length 4, early rlast on beat 2
    start(32'h3000_0200, 32'd4);
    tick();
    beat(32'hD0, 2'b00, 1'b0);
    beat(32'hD1, 2'b00, 1'b0);
    beat(32'hD2, 2'b00, 1'b1);
    idle_bus();
    chk("t5a_error", {31'd0, bus.o_wire_error}, 32'd1);
    chk("t5a_state", bus.o_wire_state, 32'd4);
    release_en();

    // Length 4, missing rlast on beat 3
    start(32'h3000_0300, 32'd4);
    tick();
    beat(32'hE0, 2'b00, 1'b0);
    beat(32'hE1, 2'b00, 1'b0);
    beat(32'hE2, 2'b00, 1'b0);
    chk("t5b_pending", bus.o_wire_state, 32'd2);
    beat(32'hE3, 2'b00, 1'b0);
    idle_bus();
    chk("t5b_error", {31'd0, bus.o_wire_error}, 32'd1);
    chk("t5b_done",  {31'd0, bus.o_wire_done}, 32'd0);
    release_en();

    // Enable dropped mid-burst: burst completes, one cycle in DONE, then IDLE
    start(32'h4000_0000, 32'd2);
    chk("t6_new_araddr", bus.o_wire_araddr, 32'h4000_0000);
    chk("t6_new_arlen",  {24'd0, bus.o_wire_arlen}, 32'd1);
    tick();
    bus.i_wire_enable = 1'b0;
    beat(32'hF0, 2'b00, 1'b0);
    chk("t6_not_aborted", bus.o_wire_state, 32'd2);
    beat(32'hF1, 2'b00, 1'b1);
    idle_bus();
    chk("t6_done_pass", bus.o_wire_state, 32'd3);
    tick();
    chk("t6_idle", bus.o_wire_state, 32'd0);
    chk("t6_done_clr", {31'd0, bus.o_wire_done}, 32'd0);

    // Asynchronous reset while in DATA
    start(32'h5000_0000, 32'd4);
    tick();
    beat(32'h60, 2'b00, 1'b0);
    bus.i_wire_rvalid = 1'b1;
    bus.i_wire_rdata  = 32'h61;
    rst = 1'b1;
    #1;
    chk("t7_state",   bus.o_wire_state, 32'd0);
    chk("t7_araddr",  bus.o_wire_araddr, 32'd0);
    chk("t7_arlen",   {24'd0, bus.o_wire_arlen}, 32'd0);
    chk("t7_rready",  {31'd0, bus.o_wire_rready}, 32'd0);
    chk("t7_wen",     {31'd0, bus.o_wire_fifo_wen}, 32'd0);
    chk("t7_wdata",   bus.o_wire_fifo_wdata, 32'd0);
    chk("t7_done",    {31'd0, bus.o_wire_done}, 32'd0);
    chk("t7_error",   {31'd0, bus.o_wire_error}, 32'd0);
    idle_bus();
    bus.i_wire_enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t7_idle_after", bus.o_wire_state, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
